// File: rtl/proc_oci_dct_capture_if.sv
// Signal bundle between the OCI DCT capture buffer and its driver/drain agent.
// The master side supplies trace words and pop requests; the slave returns drained entries and status.
interface proc_oci_dct_capture_if #(
   parameter int unsigned DCT_W = 30,
   parameter int unsigned CNT_W = 4,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ERR_W = 8
) ();
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [DCT_W-1:0]       dct_buffer;
   logic [CNT_W-1:0]       dct_count;
   logic                   dct_valid;
   logic                   test_ending;
   logic                   test_has_ended;
   logic                   rd_en;
   logic [DCT_W+CNT_W-1:0] rd_data;
   logic                   rd_valid;
   logic [LVL_W-1:0]       level;
   logic                   overflow;
   logic                   frozen;
   logic                   done;
   logic [ERR_W-1:0]       err_count;

   modport master (
      output dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, rd_en,
      input  rd_data, rd_valid, level, overflow, frozen, done, err_count
   );

   modport slave (
      input  dct_buffer, dct_count, dct_valid, test_ending, test_has_ended, rd_en,
      output rd_data, rd_valid, level, overflow, frozen, done, err_count
   );
endinterface

// File: rtl/proc_oci_dct_capture.sv
// Circular capture buffer for OCI debug-control-trace words. It freezes on test end and
// drains oldest-first. It also flags illegal slot counts and overflow.
module proc_oci_dct_capture #(
   parameter int unsigned DCT_W     = 30,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned MAX_COUNT = 3,
   parameter bit          WRAP      = 1'b0,
   parameter int unsigned ERR_W     = 8
) (
   input logic                   clk,
   input logic                   reset_n,
   proc_oci_dct_capture_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned ENT_W = DCT_W + CNT_W;

   typedef enum logic [1:0] {StCapture, StFrozen, StDone} state_e;

   state_e             state_q, state_d;
   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [ENT_W-1:0]   rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               overflow_q, overflow_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               legal, illegal, full, wr_en;

   always_comb begin
      legal   = bus.dct_valid && (bus.dct_count != '0) && (32'(bus.dct_count) <= MAX_COUNT);
      illegal = bus.dct_valid && (32'(bus.dct_count) > MAX_COUNT);
      full    = (level_q == LVL_W'(DEPTH));

      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;
      err_d      = err_q;
      wr_en      = 1'b0;

      unique case (state_q)
         StCapture: begin
            if (legal) begin
               if (!full) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  level_d  = level_q + 1'b1;
               end else begin
                  overflow_d = 1'b1;
                  // Full means wr_ptr == rd_ptr, so writing there replaces the oldest entry.
                  if (WRAP) begin
                     wr_en    = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     rd_ptr_d = rd_ptr_q + 1'b1;
                  end
               end
            end
            if (illegal && (err_q != '1)) begin
               err_d = err_q + 1'b1;
            end
            if (bus.test_ending || bus.test_has_ended) begin
               state_d = StFrozen;
            end
         end
         StFrozen: begin
            if (bus.rd_en && (level_q != '0)) begin
               rd_data_d  = mem_q[rd_ptr_q];
               rd_valid_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + 1'b1;
               level_d    = level_q - 1'b1;
            end
            if (bus.test_has_ended && (level_q == '0)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: state_d = StCapture;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StCapture;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         err_q      <= err_d;
      end
   end

   // Storage needs no reset; level and pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {bus.dct_count, bus.dct_buffer};
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.level     = level_q;
   assign bus.overflow  = overflow_q;
   assign bus.frozen    = (state_q != StCapture);
   assign bus.done      = (state_q == StDone);
   assign bus.err_count = err_q;
endmodule
